// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default operand width for serial_adder
package serial_adder_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_adder_full_adder.sv
// serial_adder_full_adder: one-bit full adder built from two half adders
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_s0, w_c0, w_c1;
  half_adder u_ha0 (.i_a(i_a), .i_b(i_b), .o_s(w_s0), .o_c(w_c0));
  half_adder u_ha1 (.i_a(w_s0), .i_b(i_c), .o_s(o_s), .o_c(w_c1));
  assign o_c = w_c0 | w_c1;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one full-adder step per RUN cycle
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_ps, r_sum, w_ps;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_cout, r_busy, r_done, w_s, w_co, w_last;
  full_adder u_fa (.i_a(r_a[0]), .i_b(r_b[0]), .i_c(r_c), .o_s(w_s), .o_c(w_co));
  assign w_last = r_cnt == CW'(WIDTH - 1);
  // sum bit enters at the MSB so after WIDTH shifts bit 0 holds the first result bit
  assign w_ps = WIDTH'({w_s, r_ps} >> 1);
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_ps   <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_next != IDLE;
      r_done <= w_next == DONE;
      if (r_state == IDLE && start) begin
        r_a   <= A;
        r_b   <= B;
        r_c   <= Cin;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_c   <= w_co;
        r_ps  <= w_ps;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_sum  <= w_ps;
          r_cout <= w_co;
        end
      end
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign Sum  = r_sum;
  assign Cout = r_cout;
endmodule
